// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the fetch/load read-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_INST,
    REQ_DATA
  } requester_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  // Word-aligned and no decoded bit above the memory's byte-address range.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input int unsigned mem_width);
    return (addr[1:0] == 2'b00) && ((addr >> mem_width) == 32'd0);
  endfunction

endpackage

// File: rtl/arb_priority_select.sv
// Combinational data-priority select with a forced fetch grant once the streak saturates.
module arb_priority_select
  import mem_arb_pkg::*;
(
  input  logic       inst_req_i,
  input  logic       data_req_i,
  input  logic       streak_max_i,
  output requester_e sel_o
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_o = REQ_NONE;
    if (data_req_i && inst_req_i) begin
      sel_o = streak_max_i ? REQ_INST : REQ_DATA;
    end else if (data_req_i) begin
      sel_o = REQ_DATA;
    end else if (inst_req_i) begin
      sel_o = REQ_INST;
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one combinational memory read port between fetch and load; responses are registered.
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_WIDTH       = 12,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  output logic        inst_err,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic [31:0] mem_address,
  output logic        mem_read_enable,
  input  logic [31:0] mem_read_data
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  logic [3:0]  streak_q, streak_d;
  logic [31:0] addr_q, addr_d;
  rsp_t        inst_rsp_q, inst_rsp_d;
  rsp_t        data_rsp_q, data_rsp_d;

  requester_e  sel;
  logic        granted;
  logic [31:0] gnt_addr;
  logic        gnt_legal;
  rsp_t        gnt_rsp;

  // Requests seen during reset are masked so nothing is granted until reset drops.
  arb_priority_select u_select (
    .inst_req_i  (inst_req & ~reset),
    .data_req_i  (data_req & ~reset),
    .streak_max_i(streak_q == STREAK_MAX),
    .sel_o       (sel)
  );

  always_comb begin
    inst_gnt  = (sel == REQ_INST);
    data_gnt  = (sel == REQ_DATA);
    granted   = inst_gnt || data_gnt;
    gnt_addr  = inst_gnt ? inst_addr : data_addr;
    gnt_legal = addr_legal(gnt_addr, MEM_WIDTH);

    mem_read_enable = granted && gnt_legal;
    if (reset) begin
      mem_address = '0;
    end else if (granted) begin
      mem_address = {gnt_addr[31:2], 2'b00};
    end else begin
      mem_address = addr_q;
    end

    gnt_rsp.valid = 1'b1;
    gnt_rsp.data  = gnt_legal ? mem_read_data : '0;
    gnt_rsp.err   = ~gnt_legal;

    addr_d = granted ? mem_address : addr_q;

    inst_rsp_d       = inst_rsp_q;
    inst_rsp_d.valid = 1'b0;
    if (inst_gnt) inst_rsp_d = gnt_rsp;

    data_rsp_d       = data_rsp_q;
    data_rsp_d.valid = 1'b0;
    if (data_gnt) data_rsp_d = gnt_rsp;

    // The streak only counts data wins that actually delayed a waiting fetch.
    streak_d = streak_q;
    if (!inst_req || inst_gnt) begin
      streak_d = '0;
    end else if (data_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q   <= '0;
      addr_q     <= '0;
      inst_rsp_q <= '0;
      data_rsp_q <= '0;
    end else begin
      streak_q   <= streak_d;
      addr_q     <= addr_d;
      inst_rsp_q <= inst_rsp_d;
      data_rsp_q <= data_rsp_d;
    end
  end

  // A response registered just before reset rises must not escape during reset.
  assign inst_rvalid = inst_rsp_q.valid & ~reset;
  assign inst_rdata  = reset ? '0 : inst_rsp_q.data;
  assign inst_err    = inst_rsp_q.err & ~reset;
  assign data_rvalid = data_rsp_q.valid & ~reset;
  assign data_rdata  = reset ? '0 : data_rsp_q.data;
  assign data_err    = data_rsp_q.err & ~reset;

endmodule
